zero_detect_scheduler: RTL and testbench

Round-robin scheduler that shares one serial "1-then-0" Mealy detector among several parallel requesters. Each requester presents a word. The scheduler grants one requester at a time, captures its word, and shifts it MSB-first through the detector. It then returns the number of 1→0 transitions in the word, tagged with the requester ID. It sits between word-wide producers and the serial detection datapath, so the detector never needs per-requester copies.

---
 rtl/zero_detect_scheduler.sv | 172 +++++++++++++++++
 tb/tb_zero_detect_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zero_detect_scheduler.sv
// zero_detect_scheduler
//
// Round-robin scheduler that shares one serial "1-then-0" Mealy detector
// among N_REQ requesters. A granted word is shifted MSB-first through the
// detector. The number of 1->0 transitions is then reported, tagged with
// the requester index.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-low reset
//   req      per-requester request level
//   data     requester i word at [i*WORD_W +: WORD_W]
//   gnt      registered one-hot grant pulse (first SHIFT cycle)
//   busy     high whenever the scheduler is not idle
//   ser_bit  bit presented to the detector (0 outside SHIFT)
//   ser_det  combinational detector output (prev_bit & ~ser_bit in SHIFT)
//   done     registered one-cycle result-valid pulse
//   done_id  requester index of the last result
//   count    1->0 transition count of the last result
module zero_detect_scheduler #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WORD_W = 8,
    parameter int unsigned ID_W   = $clog2(N_REQ),
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    ser_bit,
    output logic                    ser_det,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        count
);

    localparam int unsigned BC_W = $clog2(WORD_W);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic                prev_bit_q, prev_bit_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Round-robin search state
    logic [ID_W-1:0]     idx;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic [WORD_W-1:0]   word_sel;

    // Search last_id+1, last_id+2, ... modulo N_REQ for the first request.
    always_comb begin
        idx    = last_id_q;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (idx == ID_W'(N_REQ - 1)) begin
                idx = '0;
            end else begin
                idx = idx + ID_W'(1);
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                word_sel = data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign ser_bit = (state_q == StShift) ? shreg_q[WORD_W-1] : 1'b0;
    assign ser_det = (state_q == StShift) ? (prev_bit_q & ~ser_bit) : 1'b0;

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        shreg_d    = shreg_q;
        cur_id_d   = cur_id_q;
        last_id_d  = last_id_q;
        prev_bit_d = prev_bit_q;
        run_cnt_d  = run_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d      = N_REQ'(1) << winner;
                    shreg_d    = word_sel;
                    cur_id_d   = winner;
                    last_id_d  = winner;
                    prev_bit_d = 1'b0;
                    run_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                run_cnt_d  = run_cnt_q + CNT_W'(ser_det);
                prev_bit_d = ser_bit;
                shreg_d    = shreg_q << 1;
                bit_cnt_d  = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                    // Result includes the detection made on the last bit.
                    state_d   = StDone;
                    done_d    = 1'b1;
                    count_d   = run_cnt_q + CNT_W'(ser_det);
                    done_id_d = cur_id_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            shreg_q    <= '0;
            cur_id_q   <= '0;
            last_id_q  <= ID_W'(N_REQ - 1);
            prev_bit_q <= 1'b0;
            run_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            shreg_q    <= shreg_d;
            cur_id_q   <= cur_id_d;
            last_id_q  <= last_id_d;
            prev_bit_q <= prev_bit_d;
            run_cnt_q  <= run_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            count_q    <= count_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign count   = count_q;

endmodule

// File: tb/tb_zero_detect_scheduler.sv
module tb_zero_detect_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        busy;
    logic        ser_bit;
    logic        ser_det;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference state: pending requests, their words, round-robin pointer.
    bit [7:0] words [4];
    bit [3:0] pend;
    int       last_id;
    int       last_count;
    int       last_done_id;

    zero_detect_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .busy    (busy),
        .ser_bit (ser_bit),
        .ser_det (ser_det),
        .done    (done),
        .done_id (done_id),
        .count   (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input bit [3:0] p, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (p[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Number of adjacent (1, 0) pairs reading the word MSB first.
    function automatic int trans_count(input bit [7:0] w);
        int c = 0;
        for (int i = 7; i >= 1; i--) begin
            if (w[i] && !w[i-1]) c++;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req();
        req = pend;
        for (int i = 0; i < 4; i++) data[i*8 +: 8] = words[i];
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_ser_bit"}, {31'd0, ser_bit}, 32'd0);
        check_eq({tag, "_ser_det"}, {31'd0, ser_det}, 32'd0);
    endtask

    // Called #1 into an IDLE cycle with requests already driven. Returns
    // #1 into the IDLE cycle that follows the DONE cycle.
    // rerq: 0 never re-request, 1 randomly, 2 always.
    task automatic serve_one(input int rerq);
        int       exp_id;
        bit [7:0] w;
        bit       prev;
        exp_id = rr_pick(pend, last_id);
        w      = words[exp_id];
        tick();
        check_eq("gnt", {28'd0, gnt}, 32'd1 << exp_id);
        check_eq("busy_gnt", {31'd0, busy}, 32'd1);
        last_id      = exp_id;
        pend[exp_id] = 1'b0;
        words[exp_id] = 8'($urandom);
        if (rerq == 2 || (rerq == 1 && $urandom_range(0, 3) == 0)) pend[exp_id] = 1'b1;
        drive_req();
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                tick();
                check_eq("gnt_pulse", {28'd0, gnt}, 32'd0);
            end
            check_eq("ser_bit", {31'd0, ser_bit}, {31'd0, w[7-k]});
            check_eq("ser_det", {31'd0, ser_det}, {31'd0, prev & ~w[7-k]});
            check_eq("done_early", {31'd0, done}, 32'd0);
            prev = w[7-k];
        end
        tick();
        last_count   = trans_count(w);
        last_done_id = exp_id;
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("count", {28'd0, count}, last_count);
        check_eq("done_id", {30'd0, done_id}, last_done_id);
        check_eq("busy_done", {31'd0, busy}, 32'd1);
        tick();
        check_idle("post");
        check_eq("count_hold", {28'd0, count}, last_count);
        check_eq("id_hold", {30'd0, done_id}, last_done_id);
    endtask

    task automatic serve_word(input int id, input bit [7:0] w);
        words[id] = w;
        pend      = 4'b0001 << id;
        drive_req();
        serve_one(0);
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        data  = '0;
        pend  = '0;
        for (int i = 0; i < 4; i++) words[i] = '0;
        last_id = 3;
        tick();
        tick();
        check_idle("rst");
        check_eq("rst_count", {28'd0, count}, 32'd0);
        check_eq("rst_id", {30'd0, done_id}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("noreq");
        end

        // Directed words
        serve_word(0, 8'hB4);
        serve_word(2, 8'hAA);
        serve_word(2, 8'hFF);
        serve_word(2, 8'h00);
        serve_word(2, 8'h80);
        serve_word(0, 8'h01);
        serve_word(0, 8'h7F);

        // Round-robin skip: after 1, request 1 and 3 -> 3 then 1.
        serve_word(1, 8'h5A);
        words[1] = 8'hC3;
        words[3] = 8'h96;
        pend     = 4'b1010;
        drive_req();
        serve_one(0);
        serve_one(0);

        // Abandon a word with reset in its fourth SHIFT cycle.
        words[0] = 8'hB4;
        pend     = 4'b0001;
        drive_req();
        tick();
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_idle("midrst");
        check_eq("midrst_count", {28'd0, count}, 32'd0);
        check_eq("midrst_id", {30'd0, done_id}, 32'd0);
        pend = '0;
        drive_req();
        tick();
        check_idle("midrst_hold");
        @(negedge clock);
        reset   = 1'b1;
        last_id = 3;
        tick();
        check_idle("midrst_rel");
        serve_word(3, 8'hE2);

        // All requesters held from reset: order 0,1,2,3,0.
        reset = 1'b0;
        tick();
        @(negedge clock);
        reset   = 1'b1;
        last_id = 3;
        tick();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        pend = 4'b1111;
        drive_req();
        for (int i = 0; i < 5; i++) serve_one(2);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    words[i] = 8'($urandom);
                end
            end
            drive_req();
            if (pend == 4'b0000) begin
                tick();
                check_idle("rnd_idle");
            end else begin
                serve_one(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
